// File: rtl/fft_pkg.sv
// ============================================================================
// Module  : fft_pkg
// Brief   : Shared constants, complex type and saturation helper for the
//           32-point streaming R2SDF FFT.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int FFT_N    = 32;
    localparam int LOG2N    = 5;
    localparam int TW_W_DEF = 10;
    localparam int CPLX_W   = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Clamp a signed value to the two's-complement range of a width-bit word.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                                 input int unsigned        width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
// ============================================================================
// Module  : fft_twiddle_rom
// Brief   : Combinational 16-entry twiddle table for W32^m, m = 0..15.
//           Returns c = cos and s = -sin, so W = c + j*s, at Q2.(TW_W-2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int TW_W = TW_W_DEF
) (
    input  logic [LOG2N-2:0] i_m,
    output cplx_t            o_tw
);

    // Master table at 1.0 = 2^16, rounded half up to the requested width.
    localparam int c_SHIFT = 18 - TW_W;

    localparam int c_COS [FFT_N/2] = '{
         65536,  64277,  60547,  54491,  46341,  36410,  25080,  12785,
             0, -12785, -25080, -36410, -46341, -54491, -60547, -64277
    };

    localparam int c_NSIN [FFT_N/2] = '{
             0, -12785, -25080, -36410, -46341, -54491, -60547, -64277,
        -65536, -64277, -60547, -54491, -46341, -36410, -25080, -12785
    };

    int w_cos;
    int w_sin;

    generate
        if (c_SHIFT > 0) begin : g_round
            localparam int c_HALF = 1 << (c_SHIFT - 1);
            always_comb begin
                w_cos = (c_COS[i_m]  + c_HALF) >>> c_SHIFT;
                w_sin = (c_NSIN[i_m] + c_HALF) >>> c_SHIFT;
            end
        end else begin : g_exact
            always_comb begin
                w_cos = c_COS[i_m];
                w_sin = c_NSIN[i_m];
            end
        end
    endgenerate

    assign o_tw.re = CPLX_W'(w_cos);
    assign o_tw.im = CPLX_W'(w_sin);

endmodule

`default_nettype wire

// File: rtl/fft_r2sdf_stage.sv
// ============================================================================
// Module  : fft_r2sdf_stage
// Brief   : One radix-2 single-path delay-feedback DIF butterfly stage with
//           feedback delay DELAY; output word grows by one bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_r2sdf_stage
    import fft_pkg::*;
#(
    parameter int DELAY = 16,
    parameter int DW    = 8,
    parameter int TW_W  = TW_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic                out_valid,
    output logic signed [DW:0]  out_r,
    output logic signed [DW:0]  out_i,
    output logic                out_first
);

    localparam int c_LOG2D = $clog2(DELAY);
    localparam int c_CW    = c_LOG2D + 1;
    localparam int c_MSH   = LOG2N - 1 - c_LOG2D;
    localparam int c_PW    = DW + 1 + CPLX_W + 1;
    localparam int c_RND   = 1 << (TW_W - 3);
    localparam int c_TWSH  = TW_W - 2;

    logic [c_CW-1:0]        r_cnt;
    logic                   r_primed;
    logic signed [DW:0]     r_dly_r [DELAY];
    logic signed [DW:0]     r_dly_i [DELAY];

    logic signed [DW:0]     w_hr;
    logic signed [DW:0]     w_hi;
    logic signed [DW:0]     w_xr;
    logic signed [DW:0]     w_xi;
    logic                   w_phase_b;
    logic                   w_at_d;
    logic [LOG2N-1:0]       w_k;
    logic [LOG2N-2:0]       w_m;
    cplx_t                  w_tw;
    logic signed [CPLX_W-1:0] w_c;
    logic signed [CPLX_W-1:0] w_s;
    logic signed [c_PW-1:0] w_hr_x;
    logic signed [c_PW-1:0] w_hi_x;
    logic signed [c_PW-1:0] w_c_x;
    logic signed [c_PW-1:0] w_s_x;
    logic signed [c_PW-1:0] w_pr;
    logic signed [c_PW-1:0] w_pi;
    logic signed [c_PW-1:0] w_rr;
    logic signed [c_PW-1:0] w_ri;
    logic signed [DW:0]     w_mr;
    logic signed [DW:0]     w_mi;
    logic signed [DW:0]     w_sum_r;
    logic signed [DW:0]     w_sum_i;
    logic signed [DW:0]     w_dif_r;
    logic signed [DW:0]     w_dif_i;

    assign w_hr      = r_dly_r[DELAY-1];
    assign w_hi      = r_dly_i[DELAY-1];
    assign w_xr      = (DW+1)'(in_r);
    assign w_xi      = (DW+1)'(in_i);
    assign w_phase_b = r_cnt[c_CW-1];
    assign w_at_d    = (r_cnt == c_CW'(DELAY));

    // Twiddle exponent k = cnt mod D, stretched onto the 32-point table.
    assign w_k = LOG2N'(r_cnt) & LOG2N'(DELAY - 1);
    assign w_m = (LOG2N-1)'(w_k << c_MSH);

    fft_twiddle_rom #(
        .TW_W (TW_W)
    ) u_twiddle_rom (
        .i_m  (w_m),
        .o_tw (w_tw)
    );

    assign w_c    = w_tw.re;
    assign w_s    = w_tw.im;
    assign w_hr_x = c_PW'(w_hr);
    assign w_hi_x = c_PW'(w_hi);
    assign w_c_x  = c_PW'(w_c);
    assign w_s_x  = c_PW'(w_s);

    assign w_pr = w_hr_x * w_c_x - w_hi_x * w_s_x;
    assign w_pi = w_hr_x * w_s_x + w_hi_x * w_c_x;
    assign w_rr = (w_pr + c_PW'(c_RND)) >>> c_TWSH;
    assign w_ri = (w_pi + c_PW'(c_RND)) >>> c_TWSH;
    assign w_mr = (DW+1)'(sat_w(64'(w_rr), DW + 1));
    assign w_mi = (DW+1)'(sat_w(64'(w_ri), DW + 1));

    // Inputs are DW bits, so sum and difference always fit in DW+1.
    assign w_sum_r = w_hr + w_xr;
    assign w_sum_i = w_hi + w_xi;
    assign w_dif_r = w_hr - w_xr;
    assign w_dif_i = w_hi - w_xi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            r_dly_r   <= '{default: '0};
            r_dly_i   <= '{default: '0};
        end else begin
            out_valid <= in_valid & (r_primed | w_at_d);
            out_first <= in_valid & w_at_d;
            if (in_valid) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_at_d)
                    r_primed <= 1'b1;
                for (int n = DELAY - 1; n > 0; n--) begin
                    r_dly_r[n] <= r_dly_r[n-1];
                    r_dly_i[n] <= r_dly_i[n-1];
                end
                if (w_phase_b) begin
                    out_r      <= w_sum_r;
                    out_i      <= w_sum_i;
                    r_dly_r[0] <= w_dif_r;
                    r_dly_i[0] <= w_dif_i;
                end else begin
                    out_r      <= w_mr;
                    out_i      <= w_mi;
                    r_dly_r[0] <= w_xr;
                    r_dly_i[0] <= w_xi;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_r2sdf_stage.sv
// ============================================================================
// Module  : tb_fft_r2sdf_stage
// Brief   : Self-checking bench for fft_r2sdf_stage at DELAY=16 and DELAY=1,
//           both fed the same stream and compared to a block-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fft_r2sdf_stage;

    localparam int c_DA    = 16;
    localparam int c_DB    = 1;
    localparam int c_DW    = 8;
    localparam int c_TW    = 10;
    localparam int c_SCALE = 256;
    localparam int c_CAP   = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic signed [c_DW-1:0] in_r = '0;
    logic signed [c_DW-1:0] in_i = '0;

    logic a_valid, a_first, b_valid, b_first;
    logic signed [c_DW:0] a_r, a_i, b_r, b_i;

    always #5 clk = ~clk;

    fft_r2sdf_stage #(.DELAY(c_DA), .DW(c_DW), .TW_W(c_TW)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .out_valid(a_valid), .out_r(a_r), .out_i(a_i), .out_first(a_first)
    );

    fft_r2sdf_stage #(.DELAY(c_DB), .DW(c_DW), .TW_W(c_TW)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .out_valid(b_valid), .out_r(b_r), .out_i(b_i), .out_first(b_first)
    );

    int n_checks = 0;
    int n_errors = 0;
    int hr[$];
    int hi[$];
    int last_ar = 0, last_ai = 0, last_br = 0, last_bi = 0;
    int cap_ar[c_CAP], cap_ai[c_CAP], cap_br[c_CAP], cap_bi[c_CAP];

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat9(input int v);
        if (v > 255)  return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    function automatic int twq(input real x);
        return $rtoi($floor(x * c_SCALE + 0.5));
    endfunction

    // Output p of a stage with delay d, from the block equations over the
    // whole input history since reset.
    function automatic void model(input int d, input int p,
                                  output int er, output int ei,
                                  output bit ev, output bit ef);
        int o, base, j, jj, dr, di, c, s, m, pr, pi;
        real ang;
        er = 0; ei = 0; ev = 1'b0; ef = 1'b0;
        if (p < d) return;
        o    = p - d;
        base = (o / (2 * d)) * 2 * d;
        j    = o % (2 * d);
        ev   = 1'b1;
        ef   = (j == 0);
        if (j < d) begin
            er = hr[base+j] + hr[base+j+d];
            ei = hi[base+j] + hi[base+j+d];
        end else begin
            jj  = j - d;
            dr  = hr[base+jj] - hr[base+jj+d];
            di  = hi[base+jj] - hi[base+jj+d];
            m   = jj * (16 / d);
            ang = 2.0 * 3.14159265358979 * m / 32.0;
            c   = twq($cos(ang));
            s   = twq($sin(ang));
            pr  = dr * c + di * s;
            pi  = di * c - dr * s;
            er  = sat9((pr + c_SCALE / 2) >>> 8);
            ei  = sat9((pi + c_SCALE / 2) >>> 8);
        end
    endfunction

    task automatic chk_dut(input string tag, input int d, input bit acc, input int p,
                           input logic v, input logic f,
                           input logic signed [c_DW:0] r, input logic signed [c_DW:0] i,
                           inout int last_r, inout int last_i);
        int er, ei;
        bit ev, ef;
        if (acc) begin
            model(d, p, er, ei, ev, ef);
            check({tag, "_valid"}, v, ev);
            check({tag, "_first"}, f, ef);
            check({tag, "_re"}, r, er);
            check({tag, "_im"}, i, ei);
            last_r = er;
            last_i = ei;
        end else begin
            check({tag, "_stall_valid"}, v, 0);
            check({tag, "_stall_first"}, f, 0);
            check({tag, "_hold_re"}, r, last_r);
            check({tag, "_hold_im"}, i, last_i);
        end
    endtask

    task automatic step(input bit v, input int r, input int i);
        int p;
        @(negedge clk);
        in_valid = v;
        in_r     = c_DW'(r);
        in_i     = c_DW'(i);
        if (v) begin
            hr.push_back(r);
            hi.push_back(i);
        end
        p = hr.size() - 1;
        @(posedge clk);
        #1;
        chk_dut("dA", c_DA, v, p, a_valid, a_first, a_r, a_i, last_ar, last_ai);
        chk_dut("dB", c_DB, v, p, b_valid, b_first, b_r, b_i, last_br, last_bi);
        if (v && p >= c_DA && p - c_DA < c_CAP) begin
            cap_ar[p-c_DA] = a_r;
            cap_ai[p-c_DA] = a_i;
        end
        if (v && p >= c_DB && p - c_DB < c_CAP) begin
            cap_br[p-c_DB] = b_r;
            cap_bi[p-c_DB] = b_i;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_a_valid", a_valid, 0);
        check("rst_a_first", a_first, 0);
        check("rst_a_re", a_r, 0);
        check("rst_a_im", a_i, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_first", b_first, 0);
        check("rst_b_re", b_r, 0);
        check("rst_b_im", b_i, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        hr.delete();
        hi.delete();
        last_ar = 0; last_ai = 0; last_br = 0; last_bi = 0;
    endtask

    initial begin
        do_reset();

        // DC block then zero flush
        for (int n = 0; n < 48; n++) step(1'b1, (n < 32) ? 1 : 0, 0);

        // Same stream with a bubble after every sample
        do_reset();
        for (int n = 0; n < 48; n++) begin
            step(1'b1, (n < 32) ? 1 : 0, 0);
            step(1'b0, 0, 0);
        end

        // Single impulse at x17 exercises the W^1 twiddle
        do_reset();
        for (int n = 0; n < 48; n++) step(1'b1, (n == 17) ? 64 : 0, 0);
        check("imp_y1_re", cap_ar[1], 64);
        check("imp_y1_im", cap_ai[1], 0);
        check("imp_y17_re", cap_ar[17], -63);
        check("imp_y17_im", cap_ai[17], 13);

        // Extreme difference saturates the twiddled output
        do_reset();
        for (int n = 0; n < 48; n++) begin
            if (n == 4)       step(1'b1, 127, 127);
            else if (n == 20) step(1'b1, -128, -128);
            else              step(1'b1, 0, 0);
        end
        check("sat_y4_re", cap_ar[4], -1);
        check("sat_y4_im", cap_ai[4], -1);
        check("sat_y20_re", cap_ar[20], 255);
        check("sat_y20_im", cap_ai[20], 0);

        // D=1 back-to-back
        do_reset();
        step(1'b1, 3, 1);
        step(1'b1, 5, -2);
        step(1'b1, 0, 0);
        check("d1_y0_re", cap_br[0], 8);
        check("d1_y0_im", cap_bi[0], -1);
        check("d1_y1_re", cap_br[1], -2);
        check("d1_y1_im", cap_bi[1], 3);

        // Random stream with random stalls and a reset in the middle
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            step(($urandom % 4) != 0,
                 int'($urandom_range(255)) - 128,
                 int'($urandom_range(255)) - 128);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
